button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 36 +++
 rtl/button_debounce.sv | 45 ++++
 rtl/button_conditioner.sv | 101 ++++++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared button indices, move encodings and debounce default
//
// Purpose: constants and helpers shared by button_conditioner and button_debounce.
// Ports:   none (package).
package button_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;  // 20 ms at 50 MHz
  localparam int NUM_BTN = 5;

  // btn_raw / btn_level bit positions
  localparam int BTN_UP    = 0;
  localparam int BTN_MID   = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;

  // cmd_dir one-hot encodings
  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  // Keep only the highest-priority request: up > down > left > right,
  // which is simply the lowest set bit of the cmd_dir-ordered vector.
  function automatic logic [3:0] pick_dir(input logic [3:0] req);
    logic [3:0] res;
    res = DIR_NONE;
    if (req[0])      res = DIR_UP;
    else if (req[1]) res = DIR_DOWN;
    else if (req[2]) res = DIR_LEFT;
    else if (req[3]) res = DIR_RIGHT;
    return res;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser plus mismatch-count debouncer for one button
//
// Purpose: produce a glitch-free stable level from one asynchronous raw button.
// Ports:   clk    - system clock
//          rst_n  - asynchronous active-low reset
//          din    - raw asynchronous button input
//          level  - debounced stable level
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);

  // Counter only ever holds 0..DEBOUNCE_CYCLES-1; the flip happens instead of
  // reaching DEBOUNCE_CYCLES.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced 5-way pad to move-command handshake and game reset
//
// Purpose: debounce five buttons, turn direction presses into a one-deep
//          valid/ready move command, middle press into a game-reset pulse.
// Ports:   clk, rst_n  - clock, asynchronous active-low reset
//          btn_raw     - raw buttons (up, middle, down, left, right)
//          btn_level   - debounced levels, same order
//          cmd_valid   - move command pending
//          cmd_dir     - one-hot move (up, down, left, right), 0 when idle
//          cmd_ready   - consumer accepts the pending command
//          game_rst    - one-cycle pulse after a middle press
//          drop_cnt    - saturating count of discarded direction-press cycles
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               cmd_valid,
  output logic [3:0]         cmd_dir,
  input  logic               cmd_ready,
  output logic               game_rst,
  output logic [7:0]         drop_cnt
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (btn_raw[i]),
      .level (btn_level[i])
    );
  end

  // Previous level starts at 0, so a button held through reset shows up as a
  // fresh press once its level settles.
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press;
  logic [3:0]         dir_req;
  logic [3:0]         dir_pick;

  assign press    = btn_level & ~level_q;
  assign dir_req  = {press[BTN_RIGHT], press[BTN_LEFT], press[BTN_DOWN], press[BTN_UP]};
  assign dir_pick = pick_dir(dir_req);

  logic       valid_n;
  logic [3:0] dir_n;
  logic [7:0] drop_n;
  logic       game_rst_n;
  logic       drop;

  always_comb begin
    valid_n    = cmd_valid;
    dir_n      = cmd_dir;
    drop_n     = drop_cnt;
    game_rst_n = 1'b0;
    drop       = 1'b0;
    if (press[BTN_MID]) begin
      // Middle wins outright: any direction press this cycle is ignored and not counted.
      valid_n    = 1'b0;
      dir_n      = DIR_NONE;
      drop_n     = 8'd0;
      game_rst_n = 1'b1;
    end else begin
      if (cmd_valid && cmd_ready) begin
        valid_n = 1'b0;
        dir_n   = DIR_NONE;
      end
      if (|dir_req) begin
        if (!cmd_valid || cmd_ready) begin
          valid_n = 1'b1;
          dir_n   = dir_pick;
          drop    = (dir_req != dir_pick);
        end else begin
          drop = 1'b1;
        end
      end
      if (drop && (drop_cnt != 8'hFF)) drop_n = drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      cmd_valid <= 1'b0;
      cmd_dir   <= DIR_NONE;
      drop_cnt  <= 8'd0;
      game_rst  <= 1'b0;
    end else begin
      level_q   <= btn_level;
      cmd_valid <= valid_n;
      cmd_dir   <= dir_n;
      drop_cnt  <= drop_n;
      game_rst  <= game_rst_n;
    end
  end

endmodule
